// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: word type and RAM status encoding.
// Imported by the memory arbiter and its bench.
package cpu_types_pkg;

  localparam int WORD_BITS = 32;

  typedef logic [WORD_BITS-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/memory_arbiter.sv
// icache/dcache -> single-port RAM arbiter, dcache priority with icache
// starvation guard. Ports: CLK/RST, i* icache, d* dcache, ram* RAM side.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int WORD_W      = 32,
  parameter int ISTARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DSERVE = 2'd1,
    ISERVE = 2'd2
  } arb_state_t;

  localparam logic [3:0] STARVE_MAX = 4'(ISTARVE_MAX);

  arb_state_t        state_q, state_d;
  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic              ram_ren_q, ram_ren_d;
  logic              ram_wen_q, ram_wen_d;
  logic [WORD_W-1:0] ram_addr_q, ram_addr_d;
  logic [WORD_W-1:0] ram_store_q, ram_store_d;

  ramstate_t rstate;
  logic      d_req;
  logic      own_req;
  logic      done;
  logic      d_win;

  assign rstate = ramstate_t'(ramstate);
  assign d_req  = dREN | dWEN;

  always_comb begin
    own_req = 1'b0;
    unique case (state_q)
      DSERVE:  own_req = d_req;
      ISERVE:  own_req = iREN;
      default: own_req = 1'b0;
    endcase
  end

  // A dropped request or a reset in flight must never see a completion.
  assign done = own_req && (rstate == ACCESS) && !RST;

  // icache wins once the dcache has used up its streak.
  assign d_win = d_req && (!iREN || (starve_cnt_q < STARVE_MAX));

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    ram_ren_d    = ram_ren_q;
    ram_wen_d    = ram_wen_q;
    ram_addr_d   = ram_addr_q;
    ram_store_d  = ram_store_q;
    unique case (state_q)
      IDLE: begin
        ram_ren_d   = 1'b0;
        ram_wen_d   = 1'b0;
        ram_addr_d  = '0;
        ram_store_d = '0;
        if (!iREN) starve_cnt_d = '0;
        if (d_win) begin
          state_d     = DSERVE;
          ram_ren_d   = dREN;
          ram_wen_d   = dWEN;
          ram_addr_d  = daddr;
          ram_store_d = dWEN ? dstore : '0;
          if (iREN && starve_cnt_q < STARVE_MAX)
            starve_cnt_d = starve_cnt_q + 4'd1;
        end else if (iREN) begin
          state_d      = ISERVE;
          ram_ren_d    = 1'b1;
          ram_addr_d   = iaddr;
          starve_cnt_d = '0;
        end
      end
      DSERVE, ISERVE: begin
        if (!own_req || done) begin
          state_d     = IDLE;
          ram_ren_d   = 1'b0;
          ram_wen_d   = 1'b0;
          ram_addr_d  = '0;
          ram_store_d = '0;
        end
      end
      default: begin
        state_d     = IDLE;
        ram_ren_d   = 1'b0;
        ram_wen_d   = 1'b0;
        ram_addr_d  = '0;
        ram_store_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      ram_ren_q    <= 1'b0;
      ram_wen_q    <= 1'b0;
      ram_addr_q   <= '0;
      ram_store_q  <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      ram_ren_q    <= ram_ren_d;
      ram_wen_q    <= ram_wen_d;
      ram_addr_q   <= ram_addr_d;
      ram_store_q  <= ram_store_d;
    end
  end

  assign ramREN   = ram_ren_q;
  assign ramWEN   = ram_wen_q;
  assign ramaddr  = ram_addr_q;
  assign ramstore = ram_store_q;

  assign iwait = !(done && state_q == ISERVE);
  assign dwait = !(done && state_q == DSERVE);
  assign iload = ramload;
  assign dload = ramload;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter.
// One task per scenario, inline checks, summary at end.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        iREN = 1'b0;
  logic [31:0] iaddr = '0;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN = 1'b0;
  logic        dWEN = 1'b0;
  logic [31:0] daddr = '0;
  logic [31:0] dstore = '0;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload = '0;
  logic [1:0]  ramstate = FREE;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  memory_arbiter #(.WORD_W(32), .ISTARVE_MAX(4)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic test_reset();
    logic [3:0] a4;
    RST = 1'b1;
    ramstate = FREE;
    repeat (2) tick();
    #1;
    a4 = {iwait, dwait, ramREN, ramWEN};
    tot_cnt++;
    if (a4 !== 4'b1100) $display("FAIL rst_ctl got=%b want=1100", a4);
    else pass_cnt++;
    tot_cnt++;
    if ({ramaddr, ramstore} !== 64'h0)
      $display("FAIL rst_bus got=%h want=0", {ramaddr, ramstore});
    else pass_cnt++;
    tot_cnt++;
    if (dut.starve_cnt_q !== 4'd0)
      $display("FAIL rst_cnt got=%0d want=0", dut.starve_cnt_q);
    else pass_cnt++;
    RST = 1'b0;
    tick();
  endtask

  task automatic test_ifetch();
    logic [34:0] a;
    iREN = 1'b1; iaddr = 32'h40; ramstate = FREE;
    #1;
    tot_cnt++;
    if (ramREN !== 1'b0) $display("FAIL if_c0 got=%b want=0", ramREN);
    else pass_cnt++;
    for (int c = 1; c <= 2; c++) begin
      tick();
      ramstate = BUSY;
      #1;
      a = {ramREN, ramWEN, iwait, ramaddr};
      tot_cnt++;
      if (a !== {3'b101, 32'h40})
        $display("FAIL if_busy%0d got=%h want=%h", c, a, {3'b101, 32'h40});
      else pass_cnt++;
    end
    tick();
    ramstate = ACCESS; ramload = 32'hDEADBEEF;
    #1;
    a = {ramREN, iwait, dwait, iload};
    tot_cnt++;
    if (a !== {3'b101, 32'hDEADBEEF})
      $display("FAIL if_done got=%h want=%h", a, {3'b101, 32'hDEADBEEF});
    else pass_cnt++;
    tick();
    iREN = 1'b0; ramstate = FREE;
    #1;
    a = {ramREN, ramWEN, iwait, ramaddr};
    tot_cnt++;
    if (a !== {3'b001, 32'h0})
      $display("FAIL if_idle got=%h want=%h", a, {3'b001, 32'h0});
    else pass_cnt++;
    tick();
  endtask

  task automatic test_dpriority();
    logic [67:0] a;
    dWEN = 1'b1; daddr = 32'h80; dstore = 32'h12345678;
    iREN = 1'b1; iaddr = 32'h44; ramstate = ACCESS;
    #1;
    tot_cnt++;
    if ({iwait, dwait} !== 2'b11)
      $display("FAIL dp_c0 got=%b want=11", {iwait, dwait});
    else pass_cnt++;
    tick();
    #1;
    a = {ramREN, ramWEN, dwait, iwait, ramaddr, ramstore};
    tot_cnt++;
    if (a !== {4'b0101, 32'h80, 32'h12345678})
      $display("FAIL dp_write got=%h want=%h", a,
               {4'b0101, 32'h80, 32'h12345678});
    else pass_cnt++;
    tick();
    dWEN = 1'b0;
    #1;
    tot_cnt++;
    if ({ramREN, ramWEN, ramstore} !== 34'h0)
      $display("FAIL dp_gap got=%h want=0", {ramREN, ramWEN, ramstore});
    else pass_cnt++;
    tick();
    #1;
    a = {ramREN, ramWEN, iwait, dwait, ramaddr, ramstore};
    tot_cnt++;
    if (a !== {4'b1001, 32'h44, 32'h0})
      $display("FAIL dp_ifetch got=%h want=%h", a, {4'b1001, 32'h44, 32'h0});
    else pass_cnt++;
    tick();
    iREN = 1'b0;
    tick();
  endtask

  task automatic test_starvation();
    logic [34:0] a;
    logic [34:0] e;
    logic        ig;
    dREN = 1'b1; daddr = 32'h100;
    iREN = 1'b1; iaddr = 32'h200;
    ramstate = ACCESS;
    for (int g = 0; g < 10; g++) begin
      tick();
      #1;
      ig = (g % 5 == 4);
      e = {1'b1, !ig, ig, ig ? 32'h200 : 32'h100};
      a = {ramREN, iwait, dwait, ramaddr};
      tot_cnt++;
      if (a !== e) $display("FAIL starve_g%0d got=%h want=%h", g, a, e);
      else pass_cnt++;
      tick();
    end
    dREN = 1'b0; iREN = 1'b0;
    tick();
  endtask

  task automatic test_error_retry();
    logic [34:0] a;
    dREN = 1'b1; daddr = 32'h300; ramstate = ERROR; ramload = '0;
    tick();
    for (int k = 0; k < 3; k++) begin
      #1;
      a = {ramREN, ramWEN, dwait, ramaddr};
      tot_cnt++;
      if (a !== {3'b101, 32'h300})
        $display("FAIL err_%0d got=%h want=%h", k, a, {3'b101, 32'h300});
      else pass_cnt++;
      tick();
    end
    ramstate = ACCESS; ramload = 32'hCAFEF00D;
    #1;
    tot_cnt++;
    if ({ramREN, dwait, dload} !== {2'b10, 32'hCAFEF00D})
      $display("FAIL err_done got=%h want=%h", {ramREN, dwait, dload},
               {2'b10, 32'hCAFEF00D});
    else pass_cnt++;
    tick();
    dREN = 1'b0;
    #1;
    tot_cnt++;
    if ({ramREN, dwait} !== 2'b01)
      $display("FAIL err_idle got=%b want=01", {ramREN, dwait});
    else pass_cnt++;
    tick();
  endtask

  task automatic test_abort();
    logic [35:0] a;
    dREN = 1'b1; daddr = 32'h400;
    iREN = 1'b1; iaddr = 32'h500; ramstate = BUSY;
    tick();
    #1;
    tot_cnt++;
    if ({ramREN, ramaddr} !== {1'b1, 32'h400})
      $display("FAIL ab_grant got=%h want=%h", {ramREN, ramaddr},
               {1'b1, 32'h400});
    else pass_cnt++;
    dREN = 1'b0; ramstate = ACCESS;
    #1;
    tot_cnt++;
    if ({dwait, iwait} !== 2'b11)
      $display("FAIL ab_nodone got=%b want=11", {dwait, iwait});
    else pass_cnt++;
    tick();
    #1;
    a = {ramREN, ramWEN, dwait, iwait, ramaddr};
    tot_cnt++;
    if (a !== {4'b0011, 32'h0})
      $display("FAIL ab_idle got=%h want=%h", a, {4'b0011, 32'h0});
    else pass_cnt++;
    tick();
    #1;
    tot_cnt++;
    if ({ramREN, iwait, ramaddr} !== {2'b10, 32'h500})
      $display("FAIL ab_ifetch got=%h want=%h", {ramREN, iwait, ramaddr},
               {2'b10, 32'h500});
    else pass_cnt++;
    tick();
    iREN = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    logic [35:0] a;
    dREN = 1'b1; daddr = 32'h700;
    iREN = 1'b1; iaddr = 32'h600; ramstate = BUSY;
    tick();
    #1;
    tot_cnt++;
    if ({ramREN, ramaddr, dut.starve_cnt_q} !== {1'b1, 32'h700, 4'd1})
      $display("FAIL rm_dserve got=%h want=%h",
               {ramREN, ramaddr, dut.starve_cnt_q}, {1'b1, 32'h700, 4'd1});
    else pass_cnt++;
    RST = 1'b1;
    tick();
    RST = 1'b0; dREN = 1'b0;
    #1;
    a = {ramREN, ramWEN, dwait, iwait, ramaddr};
    tot_cnt++;
    if (a !== {4'b0011, 32'h0})
      $display("FAIL rm_d_rst got=%h want=%h", a, {4'b0011, 32'h0});
    else pass_cnt++;
    tot_cnt++;
    if (dut.starve_cnt_q !== 4'd0)
      $display("FAIL rm_cnt got=%0d want=0", dut.starve_cnt_q);
    else pass_cnt++;
    tick();
    #1;
    tot_cnt++;
    if ({ramREN, ramaddr} !== {1'b1, 32'h600})
      $display("FAIL rm_iserve got=%h want=%h", {ramREN, ramaddr},
               {1'b1, 32'h600});
    else pass_cnt++;
    RST = 1'b1;
    tick();
    RST = 1'b0; iREN = 1'b0;
    #1;
    tot_cnt++;
    if ({ramREN, iwait, ramaddr} !== {2'b01, 32'h0})
      $display("FAIL rm_i_rst got=%h want=%h", {ramREN, iwait, ramaddr},
               {2'b01, 32'h0});
    else pass_cnt++;
    tot_cnt++;
    if (dut.starve_cnt_q !== 4'd0)
      $display("FAIL rm_cnt2 got=%0d want=0", dut.starve_cnt_q);
    else pass_cnt++;
    tick();
  endtask

  initial begin
    test_reset();
    test_ifetch();
    test_dpriority();
    test_starvation();
    test_error_retry();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Two-master arbiter between the instruction cache and the data cache and the single-ported RAM. It registers one cache request at a time, drives the RAM until the access completes, and returns data and a wait handshake to the requesting cache. Data-cache requests have priority; a starvation counter guarantees instruction fetch progress.

## Interface
Parameters:
- WORD_W, 32, data and address width
- ISTARVE_MAX, 4, consecutive data-cache grants allowed while an instruction request waits (1–15)

Ports:
- CLK  in  1  system clock; everything is on the rising edge
- RST  in  1  synchronous, active-high reset
- iREN  in  1  icache read request
- iaddr  in  WORD_W  icache word address
- iwait  out  1  icache stall; low for exactly the completion cycle
- iload  out  WORD_W  icache read data; valid when iwait is low
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request (dREN and dWEN never both high)
- daddr  in  WORD_W  dcache word address
- dstore  in  WORD_W  dcache write data
- dwait  out  1  dcache stall; low for exactly the completion cycle
- dload  out  WORD_W  dcache read data; valid when dwait is low
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  WORD_W  RAM address
- ramstore  out  WORD_W  RAM write data
- ramload  in  WORD_W  RAM read data
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3

## Operation
- FSM states: IDLE, DSERVE, ISERVE.
- IDLE: arbitrate on live requests.
  - If a data request (dREN|dWEN) is present and (iREN=0 or starve_cnt<ISTARVE_MAX): go to DSERVE. Latch address, store data and direction.
  - Otherwise, if iREN is present: go to ISERVE and latch iaddr.
  - If there is no request: stay in IDLE.
- starve_cnt (4 bits):
  - Increments on each DSERVE grant made while iREN=1.
  - Clears on an ISERVE grant, and on any IDLE cycle with iREN=0.
  - Saturates at ISTARVE_MAX.
- DSERVE/ISERVE:
  - Drive ramREN/ramWEN, ramaddr and ramstore from the latched values.
  - ramstore is 0 for reads.
- Completion: in a SERVE state with ramstate=ACCESS.
  - The served cache's wait goes low that cycle, and its load output equals ramload.
  - Next state is IDLE.
- ramstate BUSY or FREE: stay in the SERVE state, with strobes held.
- ramstate ERROR: stay in the SERVE state and hold the strobes (automatic retry). No completion is signalled.
- Abort: in a SERVE state, if the owning cache drops its request before completion:
  - Return to IDLE next cycle.
  - Strobes deassert from that cycle on.
  - No completion is signalled.
- Outputs:
  - iwait/dwait are 1 at all times except the completion cycle of their own access.
  - iload/dload are ramload when not in their completion cycle (don't-care to the caches).
  - In IDLE, ramREN=ramWEN=0 and ramaddr/ramstore hold 0.

## Timing
- Reset values: state=IDLE, starve_cnt=0, iwait=dwait=1, ramREN=ramWEN=0, ramaddr=ramstore=0.
- RST asserted mid-access: the next edge forces IDLE and the strobes drop. The cache is never given a completion.
- Minimum latency: request seen in IDLE at cycle 0; RAM is driven at cycle 1; wait is low at cycle 1 if the RAM returns ACCESS in the same cycle.
- One IDLE bubble between back-to-back accesses. Throughput is at most one access per 2 cycles.
- Request changes during a SERVE state are ignored, because the latched values are used. The only exception is request deassertion, which aborts.
- Simultaneous requests with starve_cnt=ISTARVE_MAX: icache wins.

## Structure
- cpu_types_pkg provides word_t and ramstate_t (FREE/BUSY/ACCESS/ERROR).
- arb_state_t is local to the module.
- No sub-modules: one FSM plus latches and the counter, all in a single module.

## Test plan
- Reset, then iREN=1, iaddr=0x40, RAM returns ACCESS after 2 BUSY cycles with ramload=0xDEADBEEF -> ramREN=1, ramaddr=0x40 at cycles 1–3; iwait low only at cycle 3 with iload=0xDEADBEEF; back in IDLE at cycle 4.
- dWEN=1, daddr=0x80, dstore=0x12345678 concurrent with iREN=1 -> dcache served first (ramWEN=1, ramstore=0x12345678); icache is served on the next grant.
- dREN held continuously and iREN held, RAM returns ACCESS immediately -> exactly ISTARVE_MAX=4 dcache grants, then 1 icache grant, repeating.
- ramstate=ERROR for 3 cycles during a dcache read, then ACCESS -> strobes held throughout; dwait low only on the ACCESS cycle.
- dREN dropped one cycle into DSERVE -> next cycle IDLE, ramREN=0, dwait stays 1; a pending iREN is then granted.
- RST asserted during ISERVE -> next edge: ramREN=0, iwait=1, starve_cnt=0.
